// File: rtl/multipop_fifo.sv
// Circular-buffer FIFO with single push per cycle and a POP_MAX-wide peek window
// from which the consumer retires 0..POP_MAX of the oldest entries each cycle.
module multipop_fifo #(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned BITS        = 8,
  parameter int unsigned POP_MAX     = 2,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_flush,
  input  logic                           i_add,
  input  logic [BITS-1:0]                i_new_entry,
  input  logic [$clog2(POP_MAX+1)-1:0]   i_remove_count,
  output logic [POP_MAX*BITS-1:0]        o_peek_entries,
  output logic [POP_MAX-1:0]             o_peek_valid,
  output logic [$clog2(DEPTH+1)-1:0]     o_num_entries,
  output logic                           o_empty,
  output logic                           o_full,
  output logic                           o_almost_full,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned RemW = $clog2(POP_MAX + 1);
  localparam int unsigned CmpW = (CntW > RemW) ? CntW : RemW;
  localparam int unsigned SumW = CntW + 1;

  // base < DEPTH and off <= DEPTH, so one conditional subtract is an exact modulo
  // even when DEPTH is not a power of two.
  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] base,
                                              input logic [CntW-1:0] off);
    logic [SumW-1:0] sum;
    sum = SumW'(base) + SumW'(off);
    if (sum >= SumW'(DEPTH)) begin
      sum = sum - SumW'(DEPTH);
    end
    return PtrW'(sum);
  endfunction

  logic [BITS-1:0] r_storage [DEPTH];
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_num_entries;
  logic            r_overflow;
  logic            r_underflow;

  logic [PtrW-1:0] w_rd_ptr_next;
  logic [CntW-1:0] w_num_next;
  logic            w_overflow_next;
  logic            w_underflow_next;
  logic            w_underflow_evt;
  logic [CntW-1:0] w_rem;
  logic [CntW-1:0] w_after_pop;
  logic            w_accept;
  logic [PtrW-1:0] w_tail_idx;
  logic            w_wr_en;
  logic [PtrW-1:0] w_wr_idx;

  assign w_underflow_evt = CmpW'(i_remove_count) > CmpW'(r_num_entries);
  assign w_rem           = w_underflow_evt ? r_num_entries : CntW'(i_remove_count);
  assign w_after_pop     = r_num_entries - w_rem;
  assign w_accept        = i_add && (w_after_pop < CntW'(DEPTH));
  // With a full FIFO and a pop this lands on rd_ptr, which is being retired this cycle.
  assign w_tail_idx      = ptr_add(r_rd_ptr, r_num_entries);

  always_comb begin
    w_rd_ptr_next    = r_rd_ptr;
    w_num_next       = r_num_entries;
    w_overflow_next  = r_overflow;
    w_underflow_next = r_underflow;
    w_wr_en          = 1'b0;
    w_wr_idx         = '0;
    if (i_flush) begin
      w_rd_ptr_next = '0;
      w_num_next    = i_add ? CntW'(1) : '0;
      w_wr_en       = i_add;
      w_wr_idx      = '0;
    end else begin
      w_rd_ptr_next = ptr_add(r_rd_ptr, w_rem);
      w_num_next    = w_after_pop + CntW'(w_accept);
      w_wr_en       = w_accept;
      w_wr_idx      = w_tail_idx;
      if (w_underflow_evt) begin
        w_underflow_next = 1'b1;
      end
      if (i_add && !w_accept) begin
        w_overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ptr      <= '0;
      r_num_entries <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_rd_ptr      <= w_rd_ptr_next;
      r_num_entries <= w_num_next;
      r_overflow    <= w_overflow_next;
      r_underflow   <= w_underflow_next;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_en) begin
      r_storage[w_wr_idx] <= i_new_entry;
    end
  end

  for (genvar k = 0; k < POP_MAX; k++) begin : g_peek
    logic [PtrW-1:0] w_peek_idx;
    assign w_peek_idx                     = ptr_add(r_rd_ptr, CntW'(k));
    assign o_peek_entries[k*BITS +: BITS] = r_storage[w_peek_idx];
    assign o_peek_valid[k]                = (32'(r_num_entries) > k);
  end

  assign o_num_entries = r_num_entries;
  assign o_empty       = (r_num_entries == '0);
  assign o_full        = (r_num_entries == CntW'(DEPTH));
  assign o_almost_full = (32'(r_num_entries) >= AFULL_LEVEL);
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_multipop_fifo.sv
// Directed bench for multipop_fifo (DEPTH=3, BITS=8, POP_MAX=2, AFULL_LEVEL=2).
module tb_multipop_fifo;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        add;
  logic [7:0]  new_entry;
  logic [1:0]  remove_count;
  logic [15:0] peek_entries;
  logic [1:0]  peek_valid;
  logic [1:0]  num_entries;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;

  multipop_fifo #(
    .DEPTH      (3),
    .BITS       (8),
    .POP_MAX    (2),
    .AFULL_LEVEL(2)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_flush       (flush),
    .i_add         (add),
    .i_new_entry   (new_entry),
    .i_remove_count(remove_count),
    .o_peek_entries(peek_entries),
    .o_peek_valid  (peek_valid),
    .o_num_entries (num_entries),
    .o_empty       (empty),
    .o_full        (full),
    .o_almost_full (almost_full),
    .o_overflow    (overflow),
    .o_underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // remove_count above POP_MAX is illegal stimulus.
  always @(posedge clk) begin
    if (!reset) begin
      assert (remove_count <= 2'd2) else begin
        n_fail++;
        $error("FAIL illegal_remove_count observed=%0d required<=2", remove_count);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1ns after the edge.
  task automatic step(input logic rst, input logic fl, input logic ad, input logic [7:0] d,
                      input logic [1:0] rc);
    reset        = rst;
    flush        = fl;
    add          = ad;
    new_entry    = d;
    remove_count = rc;
    @(posedge clk);
    #1;
  endtask

  // Expected flags derive from expected occupancy; slots checked only when valid.
  task automatic check_state(input string tag, input int exp_num, input logic [7:0] exp_s0,
                             input logic [7:0] exp_s1, input logic exp_ovf,
                             input logic exp_unf);
    logic [1:0] exp_pv;
    exp_pv = (exp_num >= 2) ? 2'b11 : (exp_num == 1) ? 2'b01 : 2'b00;
    check({tag, ".num"},   32'(num_entries), 32'(exp_num));
    check({tag, ".pv"},    32'(peek_valid),  32'(exp_pv));
    check({tag, ".empty"}, 32'(empty),       32'(exp_num == 0));
    check({tag, ".full"},  32'(full),        32'(exp_num == 3));
    check({tag, ".afull"}, 32'(almost_full), 32'(exp_num >= 2));
    check({tag, ".ovf"},   32'(overflow),    32'(exp_ovf));
    check({tag, ".unf"},   32'(underflow),   32'(exp_unf));
    if (exp_num >= 1) check({tag, ".slot0"}, 32'(peek_entries[7:0]),  32'(exp_s0));
    if (exp_num >= 2) check({tag, ".slot1"}, 32'(peek_entries[15:8]), 32'(exp_s1));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; add = 1'b0; new_entry = '0; remove_count = '0;
    step(1, 0, 0, 8'h00, 2'd0);
    step(1, 0, 0, 8'h00, 2'd0);
    check_state("reset", 0, 8'h00, 8'h00, 0, 0);

    // Fill to full; almost_full from the second add.
    step(0, 0, 1, 8'h11, 2'd0);
    check_state("fill1", 1, 8'h11, 8'h00, 0, 0);
    step(0, 0, 1, 8'h22, 2'd0);
    check_state("fill2", 2, 8'h11, 8'h22, 0, 0);
    step(0, 0, 1, 8'h33, 2'd0);
    check_state("fill3", 3, 8'h11, 8'h22, 0, 0);

    // Push onto full with pop 2: accepted, rd_ptr 0->2, write index 0.
    step(0, 0, 1, 8'h44, 2'd2);
    check_state("full_push_pop2", 2, 8'h33, 8'h44, 0, 0);

    // Refill (write index 1), then a dropped push sets sticky overflow.
    step(0, 0, 1, 8'h66, 2'd0);
    check_state("refill", 3, 8'h33, 8'h44, 0, 0);
    step(0, 0, 1, 8'h55, 2'd0);
    check_state("overflow", 3, 8'h33, 8'h44, 1, 0);

    // Pop 1 across the wrap: rd_ptr 2->0.
    step(0, 0, 0, 8'h00, 2'd1);
    check_state("pop1_wrap", 2, 8'h44, 8'h66, 1, 0);

    // Pop 2 with push: write at index 2, rd_ptr 0->2.
    step(0, 0, 1, 8'h77, 2'd2);
    check_state("pop2_push", 1, 8'h77, 8'h00, 1, 0);

    // Over-remove with one entry: empties and sets sticky underflow.
    step(0, 0, 0, 8'h00, 2'd2);
    check_state("underflow", 0, 8'h00, 8'h00, 1, 1);
    step(0, 0, 1, 8'h88, 2'd0);
    check_state("after_unf", 1, 8'h88, 8'h00, 1, 1);

    // Reset mid-stream beats flush/add/remove.
    step(1, 1, 1, 8'hEE, 2'd1);
    check_state("reset_mid", 0, 8'h00, 8'h00, 0, 0);

    step(0, 0, 1, 8'h88, 2'd0);
    step(0, 0, 1, 8'h99, 2'd0);
    check_state("pre_flush", 2, 8'h88, 8'h99, 0, 0);

    // Flush with restart entry overrides remove_count.
    step(0, 1, 1, 8'hA5, 2'd1);
    check_state("flush_add", 1, 8'hA5, 8'h00, 0, 0);

    // Flush without add, and a flush with remove_count on empty raises no underflow.
    step(0, 1, 0, 8'h00, 2'd0);
    check_state("flush_only", 0, 8'h00, 8'h00, 0, 0);
    step(0, 1, 0, 8'h00, 2'd2);
    check_state("flush_empty_rem", 0, 8'h00, 8'h00, 0, 0);

    // Steady push+pop walks the pointers around the non-power-of-two ring.
    step(0, 0, 1, 8'h01, 2'd0);
    step(0, 0, 1, 8'h02, 2'd0);
    check_state("ring_fill", 2, 8'h01, 8'h02, 0, 0);
    step(0, 0, 1, 8'h03, 2'd1);
    check_state("ring_a", 2, 8'h02, 8'h03, 0, 0);
    step(0, 0, 1, 8'h04, 2'd1);
    check_state("ring_b", 2, 8'h03, 8'h04, 0, 0);
    step(0, 0, 1, 8'h05, 2'd0);
    check_state("ring_full", 3, 8'h03, 8'h04, 0, 0);
    step(0, 0, 0, 8'h00, 2'd2);
    check_state("ring_pop2", 1, 8'h05, 8'h00, 0, 0);
    step(0, 0, 0, 8'h00, 2'd0);
    check_state("idle", 1, 8'h05, 8'h00, 0, 0);

    // Exact pop to empty with simultaneous add on the emptied slot.
    step(0, 0, 1, 8'h5A, 2'd1);
    check_state("pop_push_one", 1, 8'h5A, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
